// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen: registered pipeline control with stall mask, multi-cycle exception flush, stall watchdog and counters
// Ports: stallreq_i per-stage stall requests (bits 0 and STAGES-1 ignored); excepttype_i exception code (0 = none);
//   cp0_epc_i ERET return address; stall_o stall mask; flush_o/new_pc_o flush and redirect target; run_o no stall/flush;
//   stall_timeout_o sticky watchdog flag; stall_cycles_o saturating stall-cycle count; flush_count_o wrapping exception count.
module pipe_ctrl_gen #(
  parameter int          STAGES       = 6,
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] INT_VECTOR   = 32'h00000020,
  parameter logic [31:0] EXC_VECTOR   = 32'h00000040,
  parameter int          WDT_LIMIT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq_i,
  input  logic [31:0]       excepttype_i,
  input  logic [31:0]       cp0_epc_i,
  output logic [STAGES-1:0] stall_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o,
  output logic              run_o,
  output logic              stall_timeout_o,
  output logic [31:0]       stall_cycles_o,
  output logic [15:0]       flush_count_o
);
  typedef enum logic {RUN, FLUSH} state_t;
  localparam int WW = $clog2(WDT_LIMIT + 1);
  state_t            state_q, state_d;
  logic [STAGES-1:0] stall_q, stall_d, mask;
  logic              flush_q, flush_d, run_q, run_d, timeout_q, timeout_d;
  logic [31:0]       new_pc_q, new_pc_d, target, stall_cycles_q, stall_cycles_d;
  logic [15:0]       flush_count_q, flush_count_d;
  logic [3:0]        flush_cnt_q, flush_cnt_d;
  logic [WW-1:0]     wdt_q, wdt_d;
  // Highest requesting middle stage k freezes stages k..0; ascending loop lets the highest bit win.
  always_comb begin
    mask = '0;
    for (int i = 1; i < STAGES - 1; i++)
      if (stallreq_i[i]) mask = {STAGES{1'b1}} >> (STAGES - 1 - i);
  end
  assign target = excepttype_i == 32'h01 ? INT_VECTOR :
                  excepttype_i == 32'h0E ? cp0_epc_i : EXC_VECTOR;
  always_comb begin
    state_d       = state_q;
    stall_d       = '0;
    flush_d       = flush_q;
    new_pc_d      = new_pc_q;
    flush_cnt_d   = flush_cnt_q;
    flush_count_d = flush_count_q;
    if (state_q == RUN) begin
      if (excepttype_i != 32'd0) begin
        state_d       = FLUSH;
        flush_d       = 1'b1;
        new_pc_d      = target;
        flush_cnt_d   = 4'(FLUSH_CYCLES - 1);
        flush_count_d = flush_count_q + 16'd1;
      end else begin
        stall_d  = mask;
        flush_d  = 1'b0;
        new_pc_d = '0;
      end
    end else if (flush_cnt_q == 4'd0) begin
      state_d  = RUN;
      flush_d  = 1'b0;
      new_pc_d = '0;
    end else flush_cnt_d = flush_cnt_q - 4'd1;
    run_d          = stall_d == '0 && !flush_d;
    // Watchdog and stall counter track the mask being registered, so they line up with stall_o.
    wdt_d          = (stall_d == '0 || flush_d) ? '0 : wdt_q == WW'(WDT_LIMIT) ? wdt_q : wdt_q + 1'b1;
    timeout_d      = timeout_q | (wdt_d == WW'(WDT_LIMIT));
    stall_cycles_d = (stall_d != '0 && stall_cycles_q != '1) ? stall_cycles_q + 32'd1 : stall_cycles_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      stall_q        <= '0;
      flush_q        <= 1'b0;
      new_pc_q       <= '0;
      run_q          <= 1'b1;
      timeout_q      <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
      flush_cnt_q    <= '0;
      wdt_q          <= '0;
    end else begin
      state_q        <= state_d;
      stall_q        <= stall_d;
      flush_q        <= flush_d;
      new_pc_q       <= new_pc_d;
      run_q          <= run_d;
      timeout_q      <= timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
      flush_cnt_q    <= flush_cnt_d;
      wdt_q          <= wdt_d;
    end
  end
  assign stall_o         = stall_q;
  assign flush_o         = flush_q;
  assign new_pc_o        = new_pc_q;
  assign run_o           = run_q;
  assign stall_timeout_o = timeout_q;
  assign stall_cycles_o  = stall_cycles_q;
  assign flush_count_o   = flush_count_q;
endmodule
